// File: rtl/mul_seq.sv
// -----------------------------------------------------------------------------
// mul_seq_pkg / mul_seq
//
// Sequential multiply unit for the RV32M multiply group. It sits beside the
// execute-stage ALU and builds the 64-bit product from four 16x16 unsigned
// partial products on one shared multiplier, then applies the sign in a final
// fix-up cycle. This suits FPGA targets with few DSP blocks.
//
// Ports
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   req_valid    in   1   issue request
//   req_ready    out  1   unit can accept (IDLE only)
//   alucode      in   6   operation; only ALU_MUL/MULH/MULHSU/MULHU accepted
//   op1          in  32   rs1 operand (multiplicand)
//   op2          in  32   rs2 operand (multiplier)
//   flush        in   1   synchronous kill of the in-flight operation
//   busy         out  1   pipeline stall (CALC or FIX)
//   resp_valid   out  1   one-cycle pulse, resp_result is new
//   resp_result  out 32   selected product word, held until the next response
//
// Timing: request sampled at edge E0, partial products at E1..E4, sign fix and
// result register at E5, resp_valid high for the cycle after E5. A new request
// may be accepted while resp_valid is high, giving one operation per 6 cycles.
// -----------------------------------------------------------------------------

package mul_seq_pkg;

  // Operation codes shared with the ALU decode.
  localparam logic [5:0] ALU_MUL    = 6'd26;
  localparam logic [5:0] ALU_MULH   = 6'd27;
  localparam logic [5:0] ALU_MULHSU = 6'd28;
  localparam logic [5:0] ALU_MULHU  = 6'd29;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

module mul_seq
  import mul_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  alucode,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        flush,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_result
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      state_q;
  state_t      state_d;

  logic [31:0] a_q;        // |op1| or op1
  logic [31:0] b_q;        // |op2| or op2
  logic        neg_q;      // final product must be negated
  logic        hi_q;       // return the upper word
  logic [63:0] acc_q;      // unsigned partial-product accumulator
  logic [1:0]  step_q;     // partial-product index within CALC

  // ---------------------------------------------------------------------------
  // Request decode and operand conditioning
  // ---------------------------------------------------------------------------
  logic        is_mul;
  logic        op1_signed;
  logic        op2_signed;
  logic        op1_neg;
  logic        op2_neg;
  logic [31:0] op1_mag;
  logic [31:0] op2_mag;
  logic        accept;

  assign is_mul = (alucode == ALU_MUL)  || (alucode == ALU_MULH) ||
                  (alucode == ALU_MULHSU) || (alucode == ALU_MULHU);

  // MUL is treated as unsigned: the low word does not depend on signedness.
  assign op1_signed = (alucode == ALU_MULH) || (alucode == ALU_MULHSU);
  assign op2_signed = (alucode == ALU_MULH);

  assign op1_neg = op1_signed && op1[31];
  assign op2_neg = op2_signed && op2[31];

  // Negating 0x80000000 yields 0x80000000, which is the correct magnitude when
  // read as unsigned.
  assign op1_mag = op1_neg ? (~op1 + 32'd1) : op1;
  assign op2_mag = op2_neg ? (~op2 + 32'd1) : op2;

  // Flush in IDLE blocks acceptance for that cycle.
  assign accept = (state_q == ST_IDLE) && req_valid && is_mul && !flush;

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_CALC;
      end
      ST_CALC: begin
        if (flush)                state_d = ST_IDLE;
        else if (step_q == 2'd3)  state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state is written only with non-blocking assignments, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_CALC) || (state_q == ST_FIX);

  // ---------------------------------------------------------------------------
  // Shared 16x16 multiplier and partial-product alignment
  // ---------------------------------------------------------------------------
  logic [15:0] mul_x;
  logic [15:0] mul_y;
  logic [31:0] mul_p;
  logic [63:0] addend;

  always_comb begin
    mul_x = a_q[15:0];
    mul_y = b_q[15:0];
    unique case (step_q)
      2'd0: begin mul_x = a_q[15:0];  mul_y = b_q[15:0];  end
      2'd1: begin mul_x = a_q[15:0];  mul_y = b_q[31:16]; end
      2'd2: begin mul_x = a_q[31:16]; mul_y = b_q[15:0];  end
      2'd3: begin mul_x = a_q[31:16]; mul_y = b_q[31:16]; end
      default: begin mul_x = a_q[15:0]; mul_y = b_q[15:0]; end
    endcase
  end

  assign mul_p = {16'd0, mul_x} * {16'd0, mul_y};

  always_comb begin
    addend = 64'd0;
    unique case (step_q)
      2'd0:    addend = {32'd0, mul_p};
      2'd1,
      2'd2:    addend = {16'd0, mul_p, 16'd0};
      2'd3:    addend = {mul_p, 32'd0};
      default: addend = 64'd0;
    endcase
  end

  // Sign fix-up; a negated zero accumulator stays zero.
  logic [63:0] product;
  assign product = neg_q ? (~acc_q + 64'd1) : acc_q;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: the operand and accumulator registers are reset along with the
  // control state; they are few, and it keeps X out of the datapath after
  // reset rather than relying on the accept path to load them first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      neg_q       <= 1'b0;
      hi_q        <= 1'b0;
      acc_q       <= 64'd0;
      step_q      <= 2'd0;
      resp_valid  <= 1'b0;
      resp_result <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            a_q    <= op1_mag;
            b_q    <= op2_mag;
            neg_q  <= op1_neg ^ op2_neg;
            hi_q   <= (alucode != ALU_MUL);
            acc_q  <= 64'd0;
            step_q <= 2'd0;
          end
        end
        ST_CALC: begin
          if (!flush) begin
            acc_q  <= acc_q + addend;
            step_q <= step_q + 2'd1;
          end
        end
        ST_FIX: begin
          // A flushed operation leaves both response outputs untouched.
          if (!flush) begin
            resp_valid  <= 1'b1;
            resp_result <= hi_q ? product[63:32] : product[31:0];
          end
        end
        default: begin
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_mul_seq
//
// Directed bench for mul_seq. Expected results are pushed to a scoreboard
// queue when a request is issued and popped when resp_valid is seen. Outputs
// are sampled on the falling clock edge; inputs change there too.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mul_seq;
  import mul_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  alucode = 6'd0;
  logic [31:0] op1 = 32'd0;
  logic [31:0] op2 = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_result;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  mul_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .alucode     (alucode),
    .op1         (op1),
    .op2         (op2),
    .flush       (flush),
    .busy        (busy),
    .resp_valid  (resp_valid),
    .resp_result (resp_result)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: sign/zero extend to 64 bits and multiply modulo 2^64.
  function automatic logic [31:0] model(input logic [5:0] code, input logic [31:0] x,
                                        input logic [31:0] y);
    logic [63:0] xe;
    logic [63:0] ye;
    logic [63:0] p;
    xe = (code == ALU_MULH || code == ALU_MULHSU) ? {{32{x[31]}}, x} : {32'd0, x};
    ye = (code == ALU_MULH) ? {{32{y[31]}}, y} : {32'd0, y};
    p  = xe * ye;
    return (code == ALU_MUL) ? p[31:0] : p[63:32];
  endfunction

  // Drive one request for a single cycle; returns at the falling edge after
  // the accept edge.
  task automatic issue(input logic [5:0] code, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    check("ready_before_issue", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    alucode   = code;
    op1       = x;
    op2       = y;
    @(negedge clk);
    req_valid = 1'b0;
    alucode   = 6'd0;
    op1       = $urandom;
    op2       = $urandom;
  endtask

  // Called at the falling edge after the accept edge; waits for resp_valid and
  // returns at the falling edge where it is high.
  task automatic wait_resp(input string tag);
    int n = 1;
    while (!resp_valid && n < 12) begin
      check({tag, "_busy"},  {31'd0, busy},      32'd1);
      check({tag, "_ready"}, {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      n++;
    end
    check({tag, "_resp_seen"}, {31'd0, resp_valid}, 32'd1);
    if (resp_valid) begin
      check({tag, "_latency"}, n, 32'd6);
      check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
      check({tag, "_ready_done"}, {31'd0, req_ready}, 32'd1);
      if (exp_q.size() == 0) begin
        check({tag, "_unexpected_resp"}, 32'd1, 32'd0);
      end else begin
        check({tag, "_result"}, resp_result, exp_q.pop_front());
      end
    end
  endtask

  task automatic do_op(input string tag, input logic [5:0] code, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp);
    exp_q.push_back(exp);
    issue(code, x, y);
    wait_resp(tag);
    @(negedge clk);
    check({tag, "_single_pulse"}, {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic idle_quiet(input string tag, input int cycles, input logic [31:0] held);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check({tag, "_no_resp"}, {31'd0, resp_valid}, 32'd0);
      check({tag, "_held"}, resp_result, held);
    end
  endtask

  initial begin
    logic [5:0] codes[4];
    codes[0] = ALU_MUL;
    codes[1] = ALU_MULH;
    codes[2] = ALU_MULHSU;
    codes[3] = ALU_MULHU;

    // Reset state.
    #12;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_result", resp_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed products.
    do_op("mul_7_m3",       ALU_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB);
    do_op("mulh_min_min",   ALU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    do_op("mulh_min_1",     ALU_MULH,   32'h8000_0000, 32'd1,         32'hFFFF_FFFF);
    do_op("mulhu_ff_ff",    ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op("mulhsu_ff_ff",   ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Flush during step 2 of a MULHU; the old result must persist.
    issue(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", {31'd0, req_ready}, 32'd1);
    check("flush_busy", {31'd0, busy}, 32'd0);
    idle_quiet("flush", 8, 32'hFFFF_FFFF);
    do_op("after_flush", ALU_MUL, 32'd3, 32'd5, 32'd15);

    // Flush in IDLE blocks acceptance.
    @(negedge clk);
    flush     = 1'b1;
    req_valid = 1'b1;
    alucode   = ALU_MUL;
    op1       = 32'd2;
    op2       = 32'd2;
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    check("idle_flush_busy", {31'd0, busy}, 32'd0);
    idle_quiet("idle_flush", 7, 32'd15);

    // Non-MUL code is ignored.
    @(negedge clk);
    req_valid = 1'b1;
    alucode   = 6'd0;
    op1       = 32'd9;
    op2       = 32'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nonmul_busy", {31'd0, busy}, 32'd0);
      check("nonmul_ready", {31'd0, req_ready}, 32'd1);
    end
    req_valid = 1'b0;
    idle_quiet("nonmul", 6, 32'd15);

    // Back-to-back: request held high; operands change after the first accept.
    @(negedge clk);
    req_valid = 1'b1;
    alucode   = ALU_MULH;
    op1       = 32'hFFFF_FFFE;
    op2       = 32'h7FFF_FFFF;
    exp_q.push_back(model(ALU_MULH, 32'hFFFF_FFFE, 32'h7FFF_FFFF));
    @(negedge clk);
    alucode   = ALU_MUL;
    op1       = 32'h1234_5678;
    op2       = 32'h9ABC_DEF0;
    exp_q.push_back(model(ALU_MUL, 32'h1234_5678, 32'h9ABC_DEF0));
    wait_resp("b2b_first");
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_single_pulse", {31'd0, resp_valid}, 32'd0);
    wait_resp("b2b_second");
    @(negedge clk);
    check("b2b_second_pulse", {31'd0, resp_valid}, 32'd0);

    // Negative zero and operand boundaries.
    do_op("mulh_zero_neg", ALU_MULH,   32'd0,         32'hFFFF_FFFB, 32'd0);
    do_op("mulhsu_min_ff", ALU_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF,
          model(ALU_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF));

    // Random operands across all codes.
    for (int i = 0; i < 12; i++) begin
      logic [5:0]  c;
      logic [31:0] x;
      logic [31:0] y;
      c = codes[i % 4];
      x = $urandom;
      y = $urandom;
      do_op("random", c, x, y, model(c, x, y));
    end

    // Asynchronous reset in the middle of CALC.
    issue(ALU_MUL, 32'd9, 32'd9);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_ready", {31'd0, req_ready}, 32'd1);
    check("async_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("async_rst_resp_result", resp_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_quiet("post_reset", 8, 32'd0);
    do_op("post_reset_op", ALU_MULHU, 32'h0001_0000, 32'h0001_0000, 32'd1);

    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
